// File: rtl/pid_regfile_if.sv
// Host register port for pid_regfile: write strobe/address/data, read
// strobe/address, and the registered read-data/valid/error responses.
interface pid_regfile_if #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 8
);
  logic              wr_en;
  logic [ADDR_W-1:0] w_addr;
  logic [DATA_W-1:0] w_data;
  logic              rd_en;
  logic [ADDR_W-1:0] r_addr;
  logic [DATA_W-1:0] r_data_o;
  logic              r_valid_o;
  logic              r_err_o;
  logic              w_err_o;

  modport master (
    output wr_en, w_addr, w_data, rd_en, r_addr,
    input  r_data_o, r_valid_o, r_err_o, w_err_o
  );

  modport slave (
    input  wr_en, w_addr, w_data, rd_en, r_addr,
    output r_data_o, r_valid_o, r_err_o, w_err_o
  );
endinterface

// File: rtl/pid_regfile.sv
// PID register file: double-buffered config registers (host writes the
// shadow copy, the active copy follows on the first sample tick after a
// commit), plain scratch storage and read-only status capture registers.
module pid_regfile #(
  parameter int DATA_W  = 16,
  parameter int ADDR_W  = 8,
  parameter int DEPTH   = 16,
  parameter int NUM_CFG = 4,
  parameter int NUM_RO  = 2
) (
  input  logic                      clk_in,
  input  logic                      reset,
  pid_regfile_if.slave              bus,
  input  logic                      commit_i,
  input  logic                      sample_tick_i,
  output logic [NUM_CFG*DATA_W-1:0] cfg_o,
  input  logic [NUM_RO*DATA_W-1:0]  status_i,
  output logic                      pending_o,
  output logic                      apply_o
);

  if (NUM_CFG + NUM_RO > DEPTH) begin : g_chk_classes
    $error("pid_regfile: NUM_CFG + NUM_RO must not exceed DEPTH");
  end
  if (DEPTH > (1 << ADDR_W)) begin : g_chk_addr
    $error("pid_regfile: DEPTH does not fit in ADDR_W address bits");
  end

  // Compare addresses one bit wider so DEPTH == 2**ADDR_W still works.
  localparam logic [ADDR_W:0] DEPTH_A   = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W:0] RO_BASE_A = (ADDR_W+1)'(DEPTH - NUM_RO);

  typedef enum logic {IDLE, ARMED} state_t;

  state_t            state_q, state_d;
  logic              apply_now;
  logic [DATA_W-1:0] regs   [DEPTH];
  logic [DATA_W-1:0] active [NUM_CFG];
  logic [DATA_W-1:0] rd_word;
  logic              r_oor;
  logic              w_bad;
  logic [DATA_W-1:0] rd_data_p1;
  logic              rd_vld_p1;
  logic              rd_err_p1;
  logic              wr_err_p1;
  logic              apply_p1;

  assign r_oor = {1'b0, bus.r_addr} >= DEPTH_A;
  // RO and out-of-range addresses both sit at or above the RO base.
  assign w_bad = {1'b0, bus.w_addr} >= RO_BASE_A;

  // Commit FSM next state: arm on commit, apply and disarm on a tick while armed.
  always_comb begin
    state_d   = state_q;
    apply_now = 1'b0;
    case (state_q)
      IDLE:  if (commit_i) state_d = ARMED;
      ARMED: if (sample_tick_i) begin
               apply_now = 1'b1;
               state_d   = IDLE;
             end
      default: state_d = IDLE;
    endcase
  end

  // Commit FSM state register and registered apply pulse.
  always_ff @(posedge clk_in or posedge reset) begin
    if (reset) begin
      state_q  <= IDLE;
      apply_p1 <= 1'b0;
    end else begin
      state_q  <= state_d;
      apply_p1 <= apply_now;
    end
  end

  // Shadow/scratch host writes and per-edge status capture.
  always_ff @(posedge clk_in or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) regs[i] <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (i >= DEPTH - NUM_RO)
          regs[i] <= status_i[(i-(DEPTH-NUM_RO))*DATA_W +: DATA_W];
        else if (bus.wr_en && (bus.w_addr == ADDR_W'(i)))
          regs[i] <= bus.w_data;
      end
    end
  end

  // Active copy takes the pre-edge shadow values, so a write in the
  // apply cycle only reaches the shadow.
  always_ff @(posedge clk_in or posedge reset) begin
    if (reset) begin
      for (int k = 0; k < NUM_CFG; k++) active[k] <= '0;
    end else if (apply_now) begin
      for (int k = 0; k < NUM_CFG; k++) active[k] <= regs[k];
    end
  end

  // Read mux over implemented registers; out-of-range reads yield 0.
  always_comb begin
    rd_word = '0;
    for (int i = 0; i < DEPTH; i++)
      if (bus.r_addr == ADDR_W'(i)) rd_word = regs[i];
  end

  // ---- stage p1: registered read response and write error ----
  // Read data holds its last value when no read is issued.
  always_ff @(posedge clk_in or posedge reset) begin
    if (reset) begin
      rd_data_p1 <= '0;
      rd_vld_p1  <= 1'b0;
      rd_err_p1  <= 1'b0;
      wr_err_p1  <= 1'b0;
    end else begin
      rd_vld_p1 <= bus.rd_en;
      rd_err_p1 <= bus.rd_en && r_oor;
      wr_err_p1 <= bus.wr_en && w_bad;
      if (bus.rd_en) rd_data_p1 <= r_oor ? '0 : rd_word;
    end
  end

  // Pack the active registers onto the config bus.
  always_comb begin
    cfg_o = '0;
    for (int k = 0; k < NUM_CFG; k++) cfg_o[k*DATA_W +: DATA_W] = active[k];
  end

  assign bus.r_data_o  = rd_data_p1;
  assign bus.r_valid_o = rd_vld_p1;
  assign bus.r_err_o   = rd_err_p1;
  assign bus.w_err_o   = wr_err_p1;
  assign pending_o     = (state_q == ARMED);
  assign apply_o       = apply_p1;

endmodule

// File: tb/tb_pid_regfile.sv
// Self-checking bench for pid_regfile: a behavioural model predicts each
// cycle, expected read responses are queued when a read is driven and
// compared when the response appears.
module tb_pid_regfile;
  localparam int DATA_W  = 16;
  localparam int ADDR_W  = 8;
  localparam int DEPTH   = 16;
  localparam int NUM_CFG = 4;
  localparam int NUM_RO  = 2;

  logic        clk_in = 1'b0;
  logic        reset;
  logic        commit_i;
  logic        sample_tick_i;
  logic [63:0] cfg_o;
  logic [31:0] status_i;
  logic        pending_o;
  logic        apply_o;

  pid_regfile_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) bus ();

  pid_regfile #(
    .DATA_W(DATA_W), .ADDR_W(ADDR_W), .DEPTH(DEPTH),
    .NUM_CFG(NUM_CFG), .NUM_RO(NUM_RO)
  ) dut (
    .clk_in        (clk_in),
    .reset         (reset),
    .bus           (bus),
    .commit_i      (commit_i),
    .sample_tick_i (sample_tick_i),
    .cfg_o         (cfg_o),
    .status_i      (status_i),
    .pending_o     (pending_o),
    .apply_o       (apply_o)
  );

  always #5 clk_in = ~clk_in;

  int checks = 0;
  int errors = 0;

  // Model state
  logic [15:0] mem [DEPTH];
  logic [15:0] act [NUM_CFG];
  logic [15:0] ro  [NUM_RO];
  logic        armed;
  logic [15:0] last_rd;
  logic [16:0] sb [$];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] mread(input int a);
    if (a >= DEPTH - NUM_RO) return ro[a - (DEPTH - NUM_RO)];
    return mem[a];
  endfunction

  task automatic model_clear();
    for (int i = 0; i < DEPTH; i++) mem[i] = '0;
    for (int k = 0; k < NUM_CFG; k++) act[k] = '0;
    for (int j = 0; j < NUM_RO; j++) ro[j] = '0;
    armed   = 1'b0;
    last_rd = '0;
    sb.delete();
  endtask

  task automatic idle_inputs();
    bus.wr_en = 0; bus.w_addr = '0; bus.w_data = '0;
    bus.rd_en = 0; bus.r_addr = '0;
    commit_i = 0; sample_tick_i = 0;
  endtask

  // One clock cycle: drive, predict, clock, compare.
  task automatic step(input logic wr, input int wa, input logic [15:0] wd,
                      input logic rd, input int ra, input logic cm, input logic tk);
    logic        exp_apply, exp_werr;
    logic [16:0] e;
    bus.wr_en = wr; bus.w_addr = wa[7:0]; bus.w_data = wd;
    bus.rd_en = rd; bus.r_addr = ra[7:0];
    commit_i = cm; sample_tick_i = tk;
    if (rd) sb.push_back((ra >= DEPTH) ? {1'b1, 16'h0000} : {1'b0, mread(ra)});
    exp_apply = armed && tk;
    if (exp_apply) for (int k = 0; k < NUM_CFG; k++) act[k] = mem[k];
    if (wr && wa < DEPTH - NUM_RO) mem[wa] = wd;
    exp_werr = wr && (wa >= DEPTH - NUM_RO);
    armed = exp_apply ? 1'b0 : (armed | cm);
    for (int j = 0; j < NUM_RO; j++) ro[j] = status_i[j*16 +: 16];
    @(posedge clk_in); #1;
    chk("r_valid", bus.r_valid_o, rd);
    if (rd) begin
      if (sb.size() == 0) chk("sb_underflow", 1, 0);
      else begin
        e = sb.pop_front();
        chk("r_data", bus.r_data_o, e[15:0]);
        chk("r_err", bus.r_err_o, e[16]);
        last_rd = e[15:0];
      end
    end else begin
      chk("r_data_hold", bus.r_data_o, last_rd);
      chk("r_err_idle", bus.r_err_o, 0);
    end
    chk("w_err", bus.w_err_o, exp_werr);
    chk("pending", pending_o, armed);
    chk("apply", apply_o, exp_apply);
    chk("cfg", cfg_o, {act[3], act[2], act[1], act[0]});
  endtask

  // Asynchronous reset asserted mid-cycle; outputs must clear immediately.
  task automatic do_reset();
    #3;
    idle_inputs();
    reset = 1'b1;
    #1;
    chk("rst_r_data", bus.r_data_o, 0);
    chk("rst_r_valid", bus.r_valid_o, 0);
    chk("rst_r_err", bus.r_err_o, 0);
    chk("rst_w_err", bus.w_err_o, 0);
    chk("rst_pending", pending_o, 0);
    chk("rst_apply", apply_o, 0);
    chk("rst_cfg", cfg_o, 0);
    model_clear();
    @(posedge clk_in); #1;
    reset = 1'b0;
  endtask

  initial begin
    status_i = {16'h0099, 16'h0042};
    idle_inputs();
    model_clear();
    reset = 1'b1;
    @(posedge clk_in); #1;
    chk("init_cfg", cfg_o, 0);
    chk("init_pending", pending_o, 0);
    chk("init_r_valid", bus.r_valid_o, 0);
    @(posedge clk_in); #1;
    reset = 1'b0;

    // Reset while armed discards the commit and the shadow
    step(1, 0, 16'h1234, 0, 0, 0, 0);
    step(0, 0, 0,        0, 0, 1, 0);
    chk("armed_before_reset", pending_o, 1);
    do_reset();
    step(0, 0, 0, 0, 0, 0, 1);
    step(0, 0, 0, 1, 0, 0, 0);

    // Shadow write, read back, delayed apply
    step(1, 1, 16'h00A5, 0, 0, 0, 0);
    step(0, 0, 0,        1, 1, 0, 0);
    step(0, 0, 0,        0, 0, 0, 1);
    step(0, 0, 0,        0, 0, 1, 0);
    step(0, 0, 0,        0, 0, 0, 0);
    step(0, 0, 0,        0, 0, 0, 1);
    chk("cfg1_applied", cfg_o[31:16], 16'h00A5);
    step(0, 0, 0,        0, 0, 0, 0);

    // Commit and tick together from IDLE: arm only
    step(1, 2, 16'h0BAD, 0, 0, 0, 0);
    step(0, 0, 0,        0, 0, 1, 1);
    step(0, 0, 0,        0, 0, 0, 0);
    step(0, 0, 0,        0, 0, 0, 1);
    // Commit repeated while armed, then commit+tick absorbs
    step(0, 0, 0,        0, 0, 1, 0);
    step(0, 0, 0,        0, 0, 1, 0);
    step(1, 3, 16'h7777, 0, 0, 1, 1);
    step(0, 0, 0,        0, 0, 0, 1);

    // Write in the apply cycle reaches only the shadow
    step(1, 0, 16'h1111, 0, 0, 0, 0);
    step(0, 0, 0,        0, 0, 1, 0);
    step(1, 0, 16'hBEEF, 0, 0, 0, 1);
    chk("cfg0_prewrite", cfg_o[15:0], 16'h1111);
    step(0, 0, 0,        1, 0, 0, 0);

    // RO and out-of-range accesses
    step(1, 14, 16'hFFFF, 0, 0,  0, 0);
    step(1, 20, 16'hFFFF, 0, 0,  0, 0);
    step(0, 0,  0,        1, 14, 0, 0);
    step(0, 0,  0,        1, 20, 0, 0);
    step(0, 0,  0,        1, 15, 0, 0);
    step(0, 0,  0,        0, 0,  0, 0);

    // Read-before-write on the same address
    step(1, 5, 16'h0003, 0, 0, 0, 0);
    step(1, 5, 16'h0007, 1, 5, 0, 0);
    step(0, 0, 0,        1, 5, 0, 0);

    // Randomised traffic including status changes and boundary addresses
    for (int n = 0; n < 60; n++) begin
      if ($urandom_range(0, 3) == 0) status_i = $urandom;
      step(1'($urandom_range(0, 1)), $urandom_range(0, 21), 16'($urandom),
           1'($urandom_range(0, 1)), $urandom_range(0, 21),
           1'($urandom_range(0, 3) == 0), 1'($urandom_range(0, 2) == 0));
    end
    step(0, 0, 0, 0, 0, 0, 0);
    chk("sb_empty", sb.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
